alu_control_pipe: RTL
=====================

Name: alu_control_pipe

Overview:
- Registered, parametrised ALU-control stage for the pipelined RV core; sits between ID/EX decode and the execute unit.
- Decodes ALUOp/funct3/funct7 into a 5-bit operation code covering RV32I arithmetic, branch compares and, optionally, the M extension.
- Holds results in an output register with a valid/ready handshake.
- Sequences multi-cycle MUL/DIV operations by withholding `out_valid` for a parametrised latency and back-pressuring the front end.

Parameters:
- OP_W, 5: operation code width; must be ≥5. Upper bits are zero-extended.
- ENABLE_M, 1: when 0, funct7=0000001 decodes as illegal.
- MUL_LAT, 3: extra cycles for MUL-class ops; must be ≥1.
- DIV_LAT, 32: extra cycles for DIV/REM-class ops; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  decode fields valid
- in_ready  out  1  stage can accept
- alu_op  in  2  00 ld/sd/I-arith, 01 branch, 10 R-type, 11 reserved
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- is_imm  in  1  I-type arithmetic (vs load/store) when alu_op=00
- out_ready  in  1  execute accepts
- out_valid  out  1  operation valid
- operation  out  OP_W  decoded operation
- illegal  out  1  unsupported encoding, qualified by out_valid
- multi_busy  out  1  multi-cycle sequence in progress

Behaviour:
- Operation codes: AND 00000, OR 00001, ADD 00010, XOR 00011, SRL 00100, SRA 00101, SUB 00110, SLT 01000, ADDI 01001, SLTU 01010, SLL 01111, MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- alu_op=00, is_imm=0: ADD for every funct3.
- alu_op=00, is_imm=1, by funct3:
  - 000 ADDI, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101: SRA if funct7[5], else SRL.
- alu_op=01, by funct3:
  - 000/001 SUB, 100/101 SLT, 110/111 SLTU.
  - 010/011: SUB with illegal=1.
- alu_op=10, by funct7:
  - 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - 0100000: 000 SUB, 101 SRA.
  - 0000001 with ENABLE_M=1: MUL..REMU in funct3 order.
  - Anything else: ADD with illegal=1.
- alu_op=11: ADD with illegal=1.
- MUL-class = codes 100xx; DIV-class = codes 101xx.
- FSM states:
  - IDLE: no valid output.
  - HOLD: out_valid=1, waiting for out_ready.
  - MULTI: counting; out_valid=0, multi_busy=1.
- in_ready = (IDLE) or (HOLD and out_ready). in_ready=0 in MULTI.
- Accept = in_valid & in_ready. On accept, operation and illegal are registered.
- Next state after accept:
  - Non-M op → HOLD; out_valid rises the next cycle (latency 1).
  - MUL-class → MULTI with cnt=MUL_LAT-1.
  - DIV-class → MULTI with cnt=DIV_LAT-1.
- In MULTI, cnt decrements each cycle; at cnt==0 the next state is HOLD. Total latency from accept to out_valid is 1+LAT.
- HOLD & out_ready & no accept → IDLE.
- HOLD & out_ready & accept: back-to-back transfer, no bubble.
- While out_valid=1 and out_ready=0, operation and illegal stay stable.
- Counter width is $clog2(max(MUL_LAT,DIV_LAT)+1); wrap-around is impossible by construction.
- flush: next state IDLE, cnt cleared, no accept that cycle (flush dominates in_valid).
- reset (async, mid-operation included): state IDLE, out_valid=0, operation=0, illegal=0, multi_busy=0, cnt=0. in_ready=1 once reset deasserts.

Decomposition:
- Package alu_ctrl_pkg holds:
  - the ALUOp localparams;
  - the operation code constants listed above;
  - the FSM state encoding;
  - function is_mul/is_div.
- Sub-module alu_op_decode: purely combinational decode to {operation, illegal}, parametrised by ENABLE_M.
- The top level holds the handshake FSM and the counter.

Test Plan:
- Reset mid-MULTI: in MULTI with cnt=20, assert reset → out_valid=0, multi_busy=0, operation=0 immediately; in_ready=1 after release.
- R-type stream with out_ready=1: alu_op=10, funct7=0100000/funct3=000, then funct7=0000000/funct3=111 on consecutive cycles → operation 00110 then 00000 one cycle later each; no bubbles; in_ready stays 1.
- I-type and load: alu_op=00, is_imm=1, funct3=000 → 01001; funct3=101, funct7=0100000 → 00101; is_imm=0, funct3=011 → 00010.
- MUL latency with MUL_LAT=3: accept alu_op=10, funct7=0000001, funct3=000 at cycle t → multi_busy=1 in t+1..t+3, in_ready=0; out_valid=1 with operation=10000 at t+4.
- Back-pressure and flush: a valid SUB is held with out_ready=0 for 5 cycles → operation stable at 00110, in_ready=0. Then assert flush together with in_valid → out_valid=0 next cycle and the new input is dropped.
- Illegal/mode: ENABLE_M=0 with funct7=0000001 → ADD, illegal=1, latency 1. alu_op=11 → illegal=1. Branch funct3=100 → 01000, illegal=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants, FSM encoding and op-class helpers for the ALU control stage
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_ADD    = 5'b00010;
    localparam logic [4:0] OP_XOR    = 5'b00011;
    localparam logic [4:0] OP_SRL    = 5'b00100;
    localparam logic [4:0] OP_SRA    = 5'b00101;
    localparam logic [4:0] OP_SUB    = 5'b00110;
    localparam logic [4:0] OP_SLT    = 5'b01000;
    localparam logic [4:0] OP_ADDI   = 5'b01001;
    localparam logic [4:0] OP_SLTU   = 5'b01010;
    localparam logic [4:0] OP_SLL    = 5'b01111;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_MULTI = 2'b10
    } state_t;

    function automatic logic is_mul(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUOp/funct3/funct7 decode to a 5-bit operation code
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_imm,
    output logic [4:0] operation,
    output logic       illegal
);

    always_comb begin
        operation = OP_ADD;
        illegal   = 1'b0;
        case (alu_op)
            ALUOP_MEM: begin
                if (is_imm) begin
                    case (funct3)
                        3'b000:  operation = OP_ADDI;
                        3'b001:  operation = OP_SLL;
                        3'b010:  operation = OP_SLT;
                        3'b011:  operation = OP_SLTU;
                        3'b100:  operation = OP_XOR;
                        3'b101:  operation = funct7[5] ? OP_SRA : OP_SRL;
                        3'b110:  operation = OP_OR;
                        default: operation = OP_AND;
                    endcase
                end
            end
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: operation = OP_SUB;
                    3'b100, 3'b101: operation = OP_SLT;
                    3'b110, 3'b111: operation = OP_SLTU;
                    default: begin
                        operation = OP_SUB;
                        illegal   = 1'b1;
                    end
                endcase
            end
            ALUOP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  operation = OP_ADD;
                        3'b001:  operation = OP_SLL;
                        3'b010:  operation = OP_SLT;
                        3'b011:  operation = OP_SLTU;
                        3'b100:  operation = OP_XOR;
                        3'b101:  operation = OP_SRL;
                        3'b110:  operation = OP_OR;
                        default: operation = OP_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    operation = OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    operation = OP_SRA;
                end else if (funct7 == F7_MEXT && ENABLE_M != 0) begin
                    // M-extension codes are laid out so funct3 maps straight onto the low bits
                    operation = {2'b10, funct3};
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_pipe.sv
// rtl/alu_control_pipe.sv - registered ALU-control stage with valid/ready handshake and multi-cycle MUL/DIV sequencing
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W     = 5,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            is_imm,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [OP_W-1:0] operation,
    output logic            illegal,
    output logic            multi_busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       op_q;
    logic             ill_q;
    logic [4:0]       dec_op;
    logic             dec_ill;
    logic             accept;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .is_imm    (is_imm),
        .operation (dec_op),
        .illegal   (dec_ill)
    );

    assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_HOLD && out_ready);
    assign accept     = in_valid && in_ready && !flush;
    assign out_valid  = (state_q == ST_HOLD);
    assign multi_busy = (state_q == ST_MULTI);
    assign operation  = OP_W'(op_q);
    assign illegal    = ill_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            // Covers both a fresh accept from IDLE and a back-to-back transfer out of HOLD
            if (is_mul(dec_op)) begin
                state_d = ST_MULTI;
                cnt_d   = MUL_CNT;
            end else if (is_div(dec_op)) begin
                state_d = ST_MULTI;
                cnt_d   = DIV_CNT;
            end else begin
                state_d = ST_HOLD;
            end
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                ST_MULTI: begin
                    if (cnt_q == '0) state_d = ST_HOLD;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q  <= dec_op;
                ill_q <= dec_ill;
            end
        end
    end

endmodule
